// File: rtl/axi_llc_plru_bist_ctrl.sv
// Sequences one BIST run of the LLC PLRU generator, accumulating the per-way
// fault vectors and classifying run-length, timeout and overrun errors.
module axi_llc_plru_bist_ctrl #(
  parameter int NumWays       = 8,
  parameter int IndexLength   = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   plru_gen_valid_o,
  input  logic                   plru_gen_ready_i,
  input  logic [NumWays-1:0]     plru_bist_res_i,
  input  logic                   plru_gen_eoc_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [NumWays-1:0]     fault_ways_o,
  output logic [IndexLength-1:0] first_fail_idx_o,
  output logic [1:0]             err_o
);

  localparam int NumSets = 2 ** IndexLength;
  localparam int CntW    = IndexLength + 1;
  localparam int TmoW    = $clog2(TimeoutCycles + 1);

  localparam logic [CntW-1:0] SetsCnt = CntW'(NumSets);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrShort   = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        beat_q, beat_d;
  logic [CntW-1:0]        beat_inc;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [NumWays-1:0]     fault_q, fault_d;
  logic [IndexLength-1:0] first_q, first_d;
  logic                   found_q, found_d;
  logic [1:0]             err_q, err_d;
  logic                   pass_q, pass_d;

  assign beat_inc = beat_q + CntOne;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    first_d = first_q;
    found_d = found_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          beat_d  = '0;
          tmo_d   = '0;
          fault_d = '0;
          first_d = '0;
          found_d = 1'b0;
          err_d   = ErrNone;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (plru_gen_ready_i) begin
          tmo_d   = '0;
          beat_d  = beat_inc;
          fault_d = fault_q | plru_bist_res_i;
          if ((plru_bist_res_i != '0) && !found_q) begin
            first_d = beat_q[IndexLength-1:0];
            found_d = 1'b1;
          end
          // An eoc after a full sweep still counts as running past the array.
          if (plru_gen_eoc_i) begin
            state_d = FINISH;
            if (beat_inc == SetsCnt) begin
              err_d = ErrNone;
            end else if (beat_inc < SetsCnt) begin
              err_d = ErrShort;
            end else begin
              err_d = ErrOverrun;
            end
          end else if (beat_q == SetsCnt) begin
            state_d = FINISH;
            err_d   = ErrOverrun;
          end
        end else begin
          tmo_d = tmo_q + TmoOne;
          if (tmo_q == TmoLast) begin
            state_d = FINISH;
            err_d   = ErrTimeout;
          end
        end
        // Verdict uses next-state values so the final beat is included.
        if (state_d == FINISH) begin
          pass_d = (fault_d == '0) && (err_d == ErrNone);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tmo_q   <= '0;
      fault_q <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      err_q   <= ErrNone;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
      first_q <= first_d;
      found_q <= found_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign plru_gen_valid_o = (state_q == RUN);
  assign busy_o           = (state_q == RUN);
  assign done_o           = (state_q == FINISH);
  assign pass_o           = pass_q;
  assign fault_ways_o     = fault_q;
  assign first_fail_idx_o = first_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_axi_llc_plru_bist_ctrl.sv
// Directed bench for the PLRU BIST controller: a run-level behavioural model
// checked every cycle, plus literal expectations for each scenario.
module tb_axi_llc_plru_bist_ctrl;

  localparam int NW = 8;
  localparam int IL = 2;
  localparam int NS = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [NW-1:0] res = '0;
  logic          eoc = 1'b0;
  logic          valid, busy, done, pass;
  logic [NW-1:0] fault;
  logic [IL-1:0] first;
  logic [1:0]    err;

  int total = 0;
  int bad   = 0;

  // Model state: phase 0 idle, 1 running, 2 finishing.
  int            m_phase = 0;
  int            m_beats = 0;
  int            m_idle  = 0;
  int            m_first = 0;
  bit            m_got   = 1'b0;
  logic [NW-1:0] m_fault = '0;
  int            m_err   = 0;
  bit            m_pass  = 1'b0;

  axi_llc_plru_bist_ctrl #(
    .NumWays(NW), .IndexLength(IL), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .plru_gen_valid_o(valid), .plru_gen_ready_i(ready),
    .plru_bist_res_i(res), .plru_gen_eoc_i(eoc),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .fault_ways_o(fault), .first_fail_idx_o(first), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model advanced on every rising edge from the sampled inputs.
  initial begin
    forever begin
      bit fin;
      @(posedge clk);
      fin = 1'b0;
      if (rst) begin
        m_phase = 0; m_beats = 0; m_idle = 0; m_first = 0; m_got = 1'b0;
        m_fault = '0; m_err = 0; m_pass = 1'b0;
      end else if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_beats = 0; m_idle = 0; m_first = 0; m_got = 1'b0;
          m_fault = '0; m_err = 0; m_pass = 1'b0;
        end
      end else if (m_phase == 1) begin
        if (ready) begin
          if (res != '0 && !m_got) begin
            m_first = m_beats % NS;
            m_got   = 1'b1;
          end
          m_fault = m_fault | res;
          m_beats++;
          m_idle = 0;
          if (eoc) begin
            fin   = 1'b1;
            m_err = (m_beats == NS) ? 0 : ((m_beats < NS) ? 2 : 3);
          end else if (m_beats > NS) begin
            fin   = 1'b1;
            m_err = 3;
          end
        end else begin
          m_idle++;
          if (m_idle >= TO) begin
            fin   = 1'b1;
            m_err = 1;
          end
        end
        if (fin) begin
          m_phase = 2;
          m_pass  = (m_fault == '0) && (m_err == 0);
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", int'(valid), int'(m_phase == 1));
      chk("busy",  int'(busy),  int'(m_phase == 1));
      chk("done",  int'(done),  int'(m_phase == 2));
      chk("pass",  int'(pass),  int'(m_pass));
      chk("fault", int'(fault), int'(m_fault));
      chk("first", int'(first), m_first);
      chk("err",   int'(err),   m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [NW-1:0] r, input logic e);
    ready = 1'b1; res = r; eoc = e;
    tick();
    ready = 1'b0; res = '0; eoc = 1'b0;
  endtask

  // Idle cycle with garbage on the qualified-by-ready inputs.
  task automatic gap();
    ready = 1'b0; res = 8'hFF; eoc = 1'b1;
    tick();
    res = '0; eoc = 1'b0;
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();

    // Clean run.
    start_run();
    chk("start_valid", int'(valid), 1);
    beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b1);
    chk("clean_done", int'(done), 1);
    chk("clean_pass", int'(pass), 1);
    chk("clean_err", int'(err), 0);
    chk("clean_valid", int'(valid), 0);
    tick();
    chk("clean_done_off", int'(done), 0);

    // Faulty ways with ignored gap cycles.
    start_run();
    beat(8'h00, 1'b0); gap(); beat(8'h04, 1'b0); gap(); beat(8'h01, 1'b0); beat(8'h00, 1'b1);
    chk("fault_done", int'(done), 1);
    chk("fault_ways", int'(fault), 5);
    chk("fault_first", int'(first), 1);
    chk("fault_pass", int'(pass), 0);
    chk("fault_err", int'(err), 0);
    tick();

    // Short run, first beat lands exactly when the timeout would expire.
    start_run();
    for (int i = 0; i < TO - 1; i++) tick();
    beat(8'h00, 1'b0);
    chk("tie_no_timeout", int'(valid), 1);
    beat(8'h00, 1'b0); beat(8'h00, 1'b1);
    chk("short_done", int'(done), 1);
    chk("short_err", int'(err), 2);
    chk("short_pass", int'(pass), 0);
    tick();

    // Timeout.
    start_run();
    n = 0;
    while (!done && n < 30) begin
      if (valid) n++;
      tick();
    end
    chk("tmo_done_seen", int'(done), 1);
    chk("tmo_run_cycles", n, TO);
    chk("tmo_err", int'(err), 1);
    chk("tmo_valid", int'(valid), 0);
    tick();

    // Overrun with a stray start mid-run.
    start_run();
    beat(8'h00, 1'b0); beat(8'h00, 1'b0);
    start = 1'b1;
    beat(8'h00, 1'b0);
    start = 1'b0;
    beat(8'h80, 1'b0);
    chk("ovr_still_running", int'(valid), 1);
    beat(8'h00, 1'b0);
    chk("ovr_done", int'(done), 1);
    chk("ovr_err", int'(err), 3);
    chk("ovr_fault", int'(fault), 8'h80);
    chk("ovr_first", int'(first), 3);
    tick();
    chk("ovr_idle", int'(valid), 0);

    // Reset mid-run, then a fresh run.
    start_run();
    beat(8'h02, 1'b0); beat(8'h00, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_valid", int'(valid), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_fault", int'(fault), 0);
    rst = 1'b0;
    tick();
    chk("mrst_no_done", int'(done), 0);
    start_run();
    beat(8'h10, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b1);
    chk("after_done", int'(done), 1);
    chk("after_first", int'(first), 0);
    chk("after_fault", int'(fault), 8'h10);
    chk("after_err", int'(err), 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
